rr_arbiter_5to1: RTL and testbench
==================================

Name: rr_arbiter_5to1

Overview:
- Round-robin arbiter that shares one 32-bit 5-to-1 mux (select values 0..4) among five requesters.
- Produces the mux select, a one-hot grant and a valid flag.
- Sits in front of the shared mux in the datapath; the mux itself stays outside this block.
- Fairness comes from a rotating priority pointer; an optional hold limit prevents any one requester from monopolising the mux.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may last; 0 = unlimited.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  5  request vector; bit i = requester i wants the mux.
- Grant  output  5  one-hot grant, registered; all zero when no owner.
- Sel  output  3  registered mux select, index of current owner (0..4).
- Valid  output  1  registered; 1 while Grant is non-zero.
- HoldCnt  output  HOLD_W  registered; cycles elapsed in current grant, starting at 1.

Behaviour:
- Reset, sampled at a rising edge of Clk while Reset=1:
  - State=IDLE, Grant=5'b00000, Sel=3'd0, Valid=0, HoldCnt=0, priority pointer Ptr=0.
  - Reset has priority over every other event, including mid-grant; the grant is dropped at that edge.
- State machine: two states, IDLE and OWNED.
- Search order: circular from Ptr, i.e. Ptr, Ptr+1, ..., Ptr+4, all mod 5. The first set Req bit in this order wins.
- IDLE:
  - Req==0: stay in IDLE; outputs unchanged.
  - Req!=0: next edge moves to OWNED with owner=winner, Grant=1<<winner, Sel=winner, Valid=1, HoldCnt=1.
  - Latency is 1 cycle: Req sampled at edge N gives Grant visible after edge N.
- OWNED, owner k. Release occurs at an edge when either:
  - Req[k]==0 at that edge, or
  - MAX_HOLD!=0 and HoldCnt==MAX_HOLD.
- OWNED, no release: Grant and Sel stay unchanged; HoldCnt increments, saturating at its maximum when MAX_HOLD=0.
- OWNED, on release:
  - Ptr=(k+1) mod 5.
  - The search runs in the same edge using the new Ptr.
  - If any Req bit is set, ownership hands directly to the winner with no idle bubble: HoldCnt=1, state stays OWNED.
  - A timed-out owner still requesting therefore has the lowest priority and regains the mux only if nobody else requests.
  - If no Req bit is set: go to IDLE; Grant=0, Valid=0, HoldCnt=0; Sel keeps its last value.
- Ptr changes only on release. The first grant out of IDLE does not modify Ptr.
- Invariants:
  - Sel is never 5, 6 or 7.
  - Grant is always zero or one-hot, with Grant[Sel]==Valid.
  - Valid==(state==OWNED).
- Simultaneous events:
  - Release and new requests arriving in the same cycle are resolved in that one edge; new requests are considered in the handoff search.
  - Req changes from non-owners never preempt the current owner.
- Req bits are assumed synchronous to Clk. No combinational path exists from Req to any output.
- Pointer wrap: owner 4 releasing sets Ptr=0.

Test Plan:
- Reset with Req=5'b11111 held for 2 cycles -> Grant=0, Sel=0, Valid=0, HoldCnt=0 throughout reset. After Reset falls, the next edge gives Grant=5'b00001, Sel=0.
- Single requester: Req=5'b00100 for 3 cycles, then 0 -> Sel=2 and Valid=1 for 3 cycles, HoldCnt=1,2,3; then Valid=0 and Sel stays 2.
- Rotation: Req=5'b10011 held, owners drop one cycle after each grant -> grant order 0, 1, 4, 0 with no idle cycles between handoffs.
- Timeout, MAX_HOLD=8: Req=5'b00011 held continuously -> requester 0 owns for 8 cycles (HoldCnt reaches 8), then Sel=1 for 8 cycles, then back to Sel=0.
- Wrap and lone-requester timeout: owner 4 with only Req[4] set, hits MAX_HOLD -> Ptr=0 and requester 4 is re-granted immediately with HoldCnt=1; Valid never drops.
- Reset mid-grant: Sel=3, HoldCnt=5, Reset pulsed for 1 cycle -> outputs return to reset values at that edge; Ptr=0, so with Req=5'b01001 the next grant goes to 0.

Source files
------------

// File: rtl/rr_arbiter_5to1_if.sv
// rtl/rr_arbiter_5to1_if.sv - request/grant bundle between five requesters and the arbiter
//
// Purpose: groups the arbiter's request input and its registered grant outputs.
// Signals:
//   req      [4:0]        bit i set = requester i wants the shared mux
//   grant    [4:0]        one-hot grant, all zero when nobody owns the mux
//   sel      [2:0]        mux select, index of the current owner (0..4)
//   valid                 1 while grant is non-zero
//   hold_cnt [HOLD_W-1:0] cycles elapsed in the current grant, starting at 1
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_5to1_if #(
  parameter int HOLD_W = 4
);
  logic [4:0]        req;
  logic [4:0]        grant;
  logic [2:0]        sel;
  logic              valid;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (output req, input grant, sel, valid, hold_cnt);
  modport slave  (input req, output grant, sel, valid, hold_cnt);
endinterface

// File: rtl/rr_arbiter_5to1.sv
// rtl/rr_arbiter_5to1.sv - round-robin arbiter for a shared 32-bit 5-to-1 mux
//
// Purpose: picks one of five requesters with a rotating priority pointer and
// drives the registered select, one-hot grant, valid and hold counter. An
// optional hold limit forces a release so no requester can keep the mux.
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  synchronous active-high reset
//   bus    rr_arbiter_5to1_if.slave (req in; grant, sel, valid, hold_cnt out)
// Parameters:
//   MAX_HOLD  maximum consecutive cycles of one grant, 0 = unlimited
//   HOLD_W    hold counter width, 2**HOLD_W > MAX_HOLD
module rr_arbiter_5to1 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rr_arbiter_5to1_if.slave     bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [4:0]        grant_q, grant_d;
  logic [2:0]        sel_q, sel_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic              owner_req;
  logic              timeout;
  logic              release_now;
  logic [2:0]        ptr_next;
  logic              found;
  logic [2:0]        win;

  // Circular search starting at p; returns {found, index}. Iterating from the
  // far end and overwriting leaves the first hit in search order.
  function automatic logic [3:0] pick(input logic [2:0] p, input logic [4:0] r);
    logic [3:0] res;
    logic [2:0] c;
    int         s;
    res = 4'b0000;
    for (int i = 4; i >= 0; i--) begin
      s = int'(p) + i;
      if (s >= 5) s = s - 5;
      c = 3'(s);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      grant_q <= 5'b00000;
      sel_q   <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    hold_d  = hold_q;

    // grant_q is one-hot while owned, so masking avoids indexing req by sel.
    owner_req   = |(bus.req & grant_q);
    timeout     = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
    release_now = (state_q == OWNED) && (!owner_req || timeout);
    ptr_next    = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;

    // On release the handoff search already uses the advanced pointer, which
    // makes a timed-out owner the last candidate.
    {found, win} = pick(release_now ? ptr_next : ptr_q, bus.req);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          grant_d = 5'b00001 << win;
          sel_d   = win;
          hold_d  = HOLD_W'(1);
        end
      end
      OWNED: begin
        if (release_now) begin
          ptr_d = ptr_next;
          if (found) begin
            grant_d = 5'b00001 << win;
            sel_d   = win;
            hold_d  = HOLD_W'(1);
          end else begin
            state_d = IDLE;
            grant_d = 5'b00000;
            hold_d  = '0;
          end
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = (state_q == OWNED);
  assign bus.hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_arbiter_5to1.sv
// tb/tb_rr_arbiter_5to1.sv - self-checking bench for rr_arbiter_5to1
module tb_rr_arbiter_5to1;

  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 4;

  logic clk;
  logic rst;

  rr_arbiter_5to1_if #(.HOLD_W(HOLD_W)) bus ();

  rr_arbiter_5to1 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic [3:0] hold;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_owned;
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_hold;

  // last observed DUT outputs
  logic [4:0] obs_grant;
  logic [2:0] obs_sel;
  logic       obs_valid;
  logic [3:0] obs_hold;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int find_win(input int p, input logic [4:0] r);
    for (int i = 0; i < 5; i++) begin
      int c;
      c = (p + i) % 5;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Advances the model by one rising edge with the given inputs.
  task automatic model_edge(input logic r, input logic [4:0] rq);
    int w;
    if (r) begin
      m_owned = 0; m_owner = 0; m_ptr = 0; m_sel = 0; m_hold = 0;
    end else if (!m_owned) begin
      w = find_win(m_ptr, rq);
      if (w >= 0) begin
        m_owned = 1; m_owner = w; m_sel = w; m_hold = 1;
      end
    end else begin
      if (!rq[m_owner] || (MAX_HOLD != 0 && m_hold == MAX_HOLD)) begin
        m_ptr = (m_owner + 1) % 5;
        w = find_win(m_ptr, rq);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_hold = 1;
        end else begin
          m_owned = 0; m_hold = 0;
        end
      end else if (m_hold < 15) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [4:0] rq);
    exp_t e;
    exp_t g;
    rst     = r;
    bus.req = rq;
    model_edge(r, rq);
    e.grant = m_owned ? (5'b00001 << m_owner) : 5'b00000;
    e.sel   = 3'(m_sel);
    e.valid = m_owned;
    e.hold  = 4'(m_hold);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_grant = bus.grant;
    obs_sel   = bus.sel;
    obs_valid = bus.valid;
    obs_hold  = bus.hold_cnt;
    g = exp_q.pop_front();
    check("sb_grant", int'(obs_grant), int'(g.grant));
    check("sb_sel",   int'(obs_sel),   int'(g.sel));
    check("sb_valid", int'(obs_valid), int'(g.valid));
    check("sb_hold",  int'(obs_hold),  int'(g.hold));
  endtask

  initial begin
    int rot_exp[4];
    logic [4:0] rq;
    rst     = 1'b1;
    bus.req = 5'b00000;
    @(negedge clk);

    // reset with all requests present
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 5'b11111);
      check("rst_grant", int'(obs_grant), 0);
      check("rst_sel",   int'(obs_sel),   0);
      check("rst_valid", int'(obs_valid), 0);
      check("rst_hold",  int'(obs_hold),  0);
    end
    step(1'b0, 5'b11111);
    check("first_grant", int'(obs_grant), 1);
    check("first_sel",   int'(obs_sel),   0);

    // single requester
    step(1'b1, 5'b00000);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 5'b00100);
      check("single_sel",   int'(obs_sel),   2);
      check("single_valid", int'(obs_valid), 1);
      check("single_hold",  int'(obs_hold),  i);
    end
    step(1'b0, 5'b00000);
    check("single_drop_valid", int'(obs_valid), 0);
    check("single_drop_sel",   int'(obs_sel),   2);
    check("single_drop_grant", int'(obs_grant), 0);

    // rotation: each owner drops the cycle after its grant
    step(1'b1, 5'b00000);
    rot_exp = '{0, 1, 4, 0};
    rq = 5'b10011;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rq);
      check("rot_sel",   int'(obs_sel),   rot_exp[i]);
      check("rot_valid", int'(obs_valid), 1);
      rq = 5'b10011 & ~obs_grant;
    end

    // timeout with two continuous requesters
    step(1'b1, 5'b00000);
    for (int s = 1; s <= 17; s++) begin
      step(1'b0, 5'b00011);
      check("to_sel",  int'(obs_sel),  (s <= 8) ? 0 : (s <= 16) ? 1 : 0);
      check("to_hold", int'(obs_hold), ((s - 1) % 8) + 1);
    end

    // lone requester 4 times out and is re-granted without a bubble
    step(1'b1, 5'b00000);
    for (int s = 1; s <= 10; s++) begin
      step(1'b0, 5'b10000);
      check("lone_valid", int'(obs_valid), 1);
      check("lone_sel",   int'(obs_sel),   4);
      check("lone_hold",  int'(obs_hold),  ((s - 1) % 8) + 1);
    end

    // reset in the middle of a grant
    step(1'b1, 5'b00000);
    for (int s = 1; s <= 5; s++) step(1'b0, 5'b01000);
    check("mid_sel",  int'(obs_sel),  3);
    check("mid_hold", int'(obs_hold), 5);
    step(1'b1, 5'b01000);
    check("mid_rst_grant", int'(obs_grant), 0);
    check("mid_rst_sel",   int'(obs_sel),   0);
    check("mid_rst_valid", int'(obs_valid), 0);
    check("mid_rst_hold",  int'(obs_hold),  0);
    step(1'b0, 5'b01001);
    check("mid_after_sel",   int'(obs_sel),   0);
    check("mid_after_grant", int'(obs_grant), 1);

    // random traffic, scoreboard only
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 12; k++) step(1'b0, bus.req | 5'($urandom_range(0, 1)));
      end
    end

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
